// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: state encoding, default geometry
// and checksum width.
package prog_loader_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_DEPTH  = 1024;
    localparam int CSUM_W     = 8;
    localparam int LEN_W      = 16;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LEN_HI  = 4'd1,
        ST_LEN_LO  = 4'd2,
        ST_DATA_HI = 4'd3,
        ST_DATA_LO = 4'd4,
        ST_WRITE   = 4'd5,
        ST_CSUM    = 4'd6,
        ST_DONE    = 4'd7,
        ST_ERR     = 4'd8
    } state_e;

    function automatic logic is_rx_state(input state_e s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA_HI) ||
               (s == ST_DATA_LO) || (s == ST_CSUM);
    endfunction

    function automatic logic is_busy_state(input state_e s);
        return is_rx_state(s) || (s == ST_WRITE);
    endfunction

endpackage

// File: rtl/prog_loader_byte_assembler.sv
// Pairs a latched high byte with the incoming low byte into one word and keeps
// the running XOR over every data byte of the session.
module prog_loader_byte_assembler
    import prog_loader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              hi_en,
    input  logic              lo_en,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word,
    output logic [CSUM_W-1:0] csum
);

    logic [7:0]        hi_q, hi_d;
    logic [CSUM_W-1:0] csum_q, csum_d;

    always_comb begin
        hi_d   = hi_q;
        csum_d = csum_q;
        if (clear) begin
            hi_d   = '0;
            csum_d = '0;
        end else begin
            if (hi_en) begin
                hi_d   = byte_in;
                csum_d = csum_d ^ byte_in;
            end
            if (lo_en) begin
                csum_d = csum_d ^ byte_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q   <= '0;
            csum_q <= '0;
        end else begin
            hi_q   <= hi_d;
            csum_q <= csum_d;
        end
    end

    // Low byte is taken live so the word is ready on the same edge it arrives.
    assign word = DATA_W'({hi_q, byte_in});
    assign csum = csum_q;

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: receives a length-prefixed, XOR-checksummed word
// stream and writes it into CPU memory port B, holding the CPU until done.
//
// state   | meaning
// IDLE    | waiting for start
// LEN_HI  | expecting length high byte
// LEN_LO  | expecting length low byte
// DATA_HI | expecting word high byte
// DATA_LO | expecting word low byte
// WRITE   | one-cycle memory write of the assembled word
// CSUM    | expecting checksum byte
// DONE    | load good, CPU released
// ERR     | length or checksum fault, CPU held
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_we,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [ADDR_W:0]   words_loaded_q, words_loaded_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_we_q, mem_we_d;
    logic              rx_ready_q, rx_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              cpu_reset_q, cpu_reset_d;

    logic              accept;
    logic              asm_clear, asm_hi_en, asm_lo_en;
    logic [DATA_W-1:0] asm_word;
    logic [CSUM_W-1:0] asm_csum;
    logic [LEN_W-1:0]  len_full;
    logic [ADDR_W:0]   wl_inc;

    assign accept   = rx_valid && rx_ready_q;
    assign len_full = {len_q[LEN_W-1:8], rx_data};
    assign wl_inc   = words_loaded_q + {{ADDR_W{1'b0}}, 1'b1};

    prog_loader_byte_assembler #(
        .DATA_W (DATA_W)
    ) u_asm (
        .clk     (clk),
        .reset   (reset),
        .clear   (asm_clear),
        .hi_en   (asm_hi_en),
        .lo_en   (asm_lo_en),
        .byte_in (rx_data),
        .word    (asm_word),
        .csum    (asm_csum)
    );

    always_comb begin
        state_d        = state_q;
        len_d          = len_q;
        words_loaded_d = words_loaded_q;
        mem_addr_d     = mem_addr_q;
        mem_data_d     = mem_data_q;
        asm_clear      = 1'b0;
        asm_hi_en      = 1'b0;
        asm_lo_en      = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d        = ST_LEN_HI;
                    words_loaded_d = '0;
                    asm_clear      = 1'b1;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_d[LEN_W-1:8] = rx_data;
                    state_d          = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_d = len_full;
                    if (len_full == '0)
                        state_d = ST_CSUM;
                    else if (32'(len_full) > 32'(DEPTH))
                        state_d = ST_ERR;
                    else
                        state_d = ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                if (accept) begin
                    asm_hi_en = 1'b1;
                    state_d   = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (accept) begin
                    asm_lo_en  = 1'b1;
                    mem_data_d = asm_word;
                    mem_addr_d = words_loaded_q[ADDR_W-1:0];
                    state_d    = ST_WRITE;
                end
            end
            ST_WRITE: begin
                words_loaded_d = wl_inc;
                state_d = (32'(wl_inc) == 32'(len_q)) ? ST_CSUM : ST_DATA_HI;
            end
            ST_CSUM: begin
                if (accept)
                    state_d = (rx_data == asm_csum) ? ST_DONE : ST_ERR;
            end
            default: state_d = ST_IDLE;
        endcase

        // Status outputs are registered decodes of the next state.
        rx_ready_d  = is_rx_state(state_d);
        busy_d      = is_busy_state(state_d);
        mem_we_d    = (state_d == ST_WRITE);
        done_d      = (state_d == ST_DONE);
        error_d     = (state_d == ST_ERR);
        cpu_reset_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            len_q          <= '0;
            words_loaded_q <= '0;
            mem_addr_q     <= '0;
            mem_data_q     <= '0;
            mem_we_q       <= 1'b0;
            rx_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            cpu_reset_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            words_loaded_q <= words_loaded_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_q     <= mem_data_d;
            mem_we_q       <= mem_we_d;
            rx_ready_q     <= rx_ready_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
            cpu_reset_q    <= cpu_reset_d;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign mem_addr     = mem_addr_q;
    assign mem_data     = mem_data_q;
    assign mem_we       = mem_we_q;
    assign cpu_reset    = cpu_reset_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: hand-computed byte streams, write capture
// and status checks after each session.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [9:0]  mem_addr;
    logic [15:0] mem_data;
    logic        mem_we;
    logic        cpu_reset;
    logic        busy, done, error;
    logic [10:0] words_loaded;

    int n_cmp = 0;
    int n_mis = 0;

    logic [9:0]  wa_q[$];
    logic [15:0] wd_q[$];

    prog_loader #(.ADDR_W(10), .DATA_W(16), .DEPTH(1024)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_we       (mem_we),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_data);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
    endtask

    initial begin
        logic [7:0]  cs;
        logic [15:0] w;
        int          bad;

        // reset values
        #12;
        chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        chk("rst_mem_data", {16'd0, mem_data}, 32'd0);
        chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        chk("rst_status", {29'd0, busy, done, error}, 32'd0);
        chk("rst_words", {21'd0, words_loaded}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_rx_ready", {31'd0, rx_ready}, 32'd0);

        // two-word load with good checksum
        clear_log();
        pulse_start();
        chk("a_busy", {31'd0, busy}, 32'd1);
        chk("a_rx_ready", {31'd0, rx_ready}, 32'd1);
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hAB); send_byte(8'hCD);
        send_byte(8'h40);
        chk("a_done", {31'd0, done}, 32'd1);
        chk("a_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("a_words", {21'd0, words_loaded}, 32'd2);
        chk("a_nwrites", wa_q.size(), 32'd2);
        if (wa_q.size() == 2) begin
            chk("a_w0", {6'd0, wa_q[0], wd_q[0]}, {6'd0, 10'd0, 16'h1234});
            chk("a_w1", {6'd0, wa_q[1], wd_q[1]}, {6'd0, 10'd1, 16'hABCD});
        end
        chk("a_busy_err", {30'd0, busy, error}, 32'd0);

        // restart from DONE, one word with bad checksum
        clear_log();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b_cpu_reset_drop", {31'd0, cpu_reset}, 32'd0);
        chk("b_restart", {29'd0, busy, done, error}, 32'b100);
        chk("b_words_clr", {21'd0, words_loaded}, 32'd0);
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h00);
        chk("b_error", {31'd0, error}, 32'd1);
        chk("b_done", {31'd0, done}, 32'd0);
        chk("b_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        chk("b_nwrites", wa_q.size(), 32'd1);
        if (wa_q.size() == 1)
            chk("b_w0", {6'd0, wa_q[0], wd_q[0]}, {6'd0, 10'd0, 16'h1234});

        // oversize length 0x0401
        clear_log();
        pulse_start();
        send_byte(8'h04); send_byte(8'h01);
        chk("c_error", {29'd0, busy, done, error}, 32'b001);
        repeat (4) @(negedge clk);
        chk("c_nwrites", wa_q.size(), 32'd0);

        // zero-length load with 5-cycle rx_valid gaps
        clear_log();
        pulse_start();
        repeat (5) @(negedge clk);
        chk("d_gap0", {30'd0, busy, rx_ready}, 32'b11);
        send_byte(8'h00);
        repeat (5) @(negedge clk);
        chk("d_gap1", {30'd0, busy, rx_ready}, 32'b11);
        send_byte(8'h00);
        repeat (5) @(negedge clk);
        chk("d_gap2", {30'd0, busy, rx_ready}, 32'b11);
        send_byte(8'h00);
        chk("d_done", {29'd0, busy, done, error}, 32'b010);
        chk("d_words", {21'd0, words_loaded}, 32'd0);
        chk("d_nwrites", wa_q.size(), 32'd0);

        // reset during DATA_LO of the fourth word
        clear_log();
        pulse_start();
        send_byte(8'h00); send_byte(8'h05);
        send_byte(8'h11); send_byte(8'h22);
        send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66);
        send_byte(8'h77);
        chk("e_in_data_lo", {30'd0, rx_ready, busy}, 32'b11);
        #2;
        reset = 1'b0;
        #1;
        chk("e_rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        chk("e_rst_status", {28'd0, busy, done, error, cpu_reset}, 32'd0);
        chk("e_rst_mem", {5'd0, mem_we, mem_addr, mem_data}, 32'd0);
        chk("e_rst_words", {21'd0, words_loaded}, 32'd0);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("e_wait_idle", {30'd0, busy, rx_ready}, 32'd0);
        chk("e_nwrites", wa_q.size(), 32'd3);
        clear_log();
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hBE); send_byte(8'hEF);
        send_byte(8'h51);
        chk("e_reload_done", {29'd0, busy, done, error}, 32'b010);
        chk("e_reload_nwrites", wa_q.size(), 32'd1);
        if (wa_q.size() == 1)
            chk("e_reload_w0", {6'd0, wa_q[0], wd_q[0]}, {6'd0, 10'd0, 16'hBEEF});

        // full-depth load
        clear_log();
        pulse_start();
        send_byte(8'h04); send_byte(8'h00);
        cs = 8'h00;
        for (int i = 0; i < 1024; i++) begin
            w  = 16'(i) ^ 16'hC3A0;
            cs = cs ^ w[15:8] ^ w[7:0];
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
        send_byte(cs);
        chk("f_done", {29'd0, busy, done, error}, 32'b010);
        chk("f_words", {21'd0, words_loaded}, 32'd1024);
        chk("f_nwrites", wa_q.size(), 32'd1024);
        bad = 0;
        for (int i = 0; i < wa_q.size(); i++) begin
            w = 16'(i) ^ 16'hC3A0;
            if (wa_q[i] !== 10'(i) || wd_q[i] !== w) bad++;
        end
        chk("f_seq_errors", bad, 32'd0);
        if (wa_q.size() == 1024)
            chk("f_last", {6'd0, wa_q[1023], wd_q[1023]}, {6'd0, 10'h3FF, 16'h03FF ^ 16'hC3A0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
